// File: rtl/fc_layer_seq.sv
// fc_layer_seq: sequential fully-connected layer with one signed fixed-point MAC
// and a running argmax. Weights and biases come from external synchronous
// memories. Read data arrives one cycle after the address is driven.
module fc_layer_seq #(
    parameter int IN_N  = 120,
    parameter int OUT_N = 84,
    parameter int DW    = 16,
    parameter int FRAC  = 8,
    parameter int RELU  = 1,
    localparam int WAW  = (IN_N * OUT_N > 1) ? $clog2(IN_N * OUT_N) : 1,
    localparam int BAW  = (OUT_N > 1) ? $clog2(OUT_N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DW-1:0]  in_data,
    output logic [WAW-1:0] w_addr,
    input  logic [DW-1:0]  w_rdata,
    output logic [BAW-1:0] b_addr,
    input  logic [DW-1:0]  b_rdata,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  out_data,
    output logic [BAW-1:0] out_idx,
    output logic           done,
    output logic [BAW-1:0] class_idx,
    output logic           class_valid
);
    localparam int KW    = $clog2(IN_N);
    localparam int ACC_W = 2 * DW + $clog2(IN_N) + 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {LOAD, BIAS, MAC, POST, OUT, DONE} state_t;

    state_t                  state;
    logic [KW-1:0]           k;
    logic [BAW-1:0]          j;
    logic signed [ACC_W-1:0] acc;
    logic signed [DW-1:0]    x_buf [IN_N];
    logic signed [DW-1:0]    best;
    logic [BAW-1:0]          best_idx;

    logic signed [DW-1:0]    x_cur;
    logic signed [2*DW-1:0]  x_ext, w_ext, prod;
    logic signed [ACC_W-1:0] prod_ext, bias_ext, bias_sh, shifted;
    logic signed [DW-1:0]    r_sat;

    // Datapath: full-width signed product, bias aligned to the product's Q point.
    assign x_cur    = x_buf[k];
    assign x_ext    = {{DW{x_cur[DW-1]}}, x_cur};
    assign w_ext    = {{DW{w_rdata[DW-1]}}, w_rdata};
    assign prod     = x_ext * w_ext;
    assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
    assign bias_ext = {{(ACC_W-DW){b_rdata[DW-1]}}, b_rdata};
    assign bias_sh  = bias_ext <<< FRAC;
    assign shifted  = acc >>> FRAC;

    // Rescale result: saturate to DW bits, then optional ReLU clamp.
    always_comb begin
        r_sat = shifted[DW-1:0];
        if (shifted > SAT_MAX)
            r_sat = SAT_MAX[DW-1:0];
        else if (shifted < SAT_MIN)
            r_sat = SAT_MIN[DW-1:0];
        if (RELU != 0 && r_sat[DW-1])
            r_sat = '0;
    end

    // Input vector buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (state == LOAD && in_valid)
            x_buf[k] <= in_data;
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOAD;
            k           <= '0;
            j           <= '0;
            acc         <= '0;
            best        <= '0;
            best_idx    <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_idx     <= '0;
            done        <= 1'b0;
            class_idx   <= '0;
            class_valid <= 1'b0;
            w_addr      <= '0;
            b_addr      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        class_valid <= 1'b0;
                        if (k == KW'(IN_N - 1)) begin
                            k        <= '0;
                            j        <= '0;
                            w_addr   <= '0;
                            b_addr   <= '0;
                            in_ready <= 1'b0;
                            state    <= BIAS;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                BIAS: begin
                    // Row base is on w_addr now; element 1's address goes out next.
                    k      <= '0;
                    w_addr <= w_addr + 1'b1;
                    state  <= MAC;
                end
                MAC: begin
                    if (k == '0)
                        acc <= bias_sh + prod_ext;
                    else
                        acc <= acc + prod_ext;
                    // Stop advancing once the row's last element is addressed.
                    if (k < KW'(IN_N - 2))
                        w_addr <= w_addr + 1'b1;
                    if (k == KW'(IN_N - 1))
                        state <= POST;
                    else
                        k <= k + 1'b1;
                end
                POST: begin
                    out_data  <= r_sat;
                    out_idx   <= j;
                    out_valid <= 1'b1;
                    // Strict compare keeps the lowest index on ties.
                    if (j == '0 || r_sat > best) begin
                        best     <= r_sat;
                        best_idx <= j;
                    end
                    state <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (j == BAW'(OUT_N - 1)) begin
                            done        <= 1'b1;
                            class_idx   <= best_idx;
                            class_valid <= 1'b1;
                            state       <= DONE;
                        end else begin
                            j      <= j + 1'b1;
                            b_addr <= j + 1'b1;
                            w_addr <= w_addr + 1'b1;
                            state  <= BIAS;
                        end
                    end
                end
                DONE: begin
                    k        <= '0;
                    in_ready <= 1'b1;
                    state    <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_layer_seq.sv
// Directed bench for fc_layer_seq (IN_N=4, OUT_N=3). Two instances, ReLU on and
// off, share every input and run in lockstep; each has its own memory read port.
module tb_fc_layer_seq;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready;
    logic [15:0] in_data;

    logic        in_ready_r, out_valid_r, done_r, cv_r;
    logic [3:0]  w_addr_r;
    logic [1:0]  b_addr_r, out_idx_r, cls_r;
    logic [15:0] w_rd_r, b_rd_r, out_data_r;

    logic        in_ready_l, out_valid_l, done_l, cv_l;
    logic [3:0]  w_addr_l;
    logic [1:0]  b_addr_l, out_idx_l, cls_l;
    logic [15:0] w_rd_l, b_rd_l, out_data_l;

    logic [15:0] wmem [0:11];
    logic [15:0] bmem [0:2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int first_cyc, last_cyc;
    logic cv_before, cv_after;

    logic [15:0] od_r [0:3];
    logic [15:0] od_l [0:3];
    int          otag [0:3];

    fc_layer_seq #(.IN_N(4), .OUT_N(3), .DW(16), .FRAC(8), .RELU(1)) u_relu (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r),
        .in_data(in_data), .w_addr(w_addr_r), .w_rdata(w_rd_r), .b_addr(b_addr_r),
        .b_rdata(b_rd_r), .out_valid(out_valid_r), .out_ready(out_ready),
        .out_data(out_data_r), .out_idx(out_idx_r), .done(done_r),
        .class_idx(cls_r), .class_valid(cv_r));

    fc_layer_seq #(.IN_N(4), .OUT_N(3), .DW(16), .FRAC(8), .RELU(0)) u_lin (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l),
        .in_data(in_data), .w_addr(w_addr_l), .w_rdata(w_rd_l), .b_addr(b_addr_l),
        .b_rdata(b_rd_l), .out_valid(out_valid_l), .out_ready(out_ready),
        .out_data(out_data_l), .out_idx(out_idx_l), .done(done_l),
        .class_idx(cls_l), .class_valid(cv_l));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous weight/bias memories, one read port per instance.
    always @(posedge clk) begin
        w_rd_r <= wmem[w_addr_r];
        b_rd_r <= bmem[b_addr_r];
        w_rd_l <= wmem[w_addr_l];
        b_rd_l <= bmem[b_addr_l];
    end

    // Capture activations by neuron index, tagged with the done count.
    always @(negedge clk) begin
        if (out_valid_r) begin
            od_r[out_idx_r] <= out_data_r;
            od_l[out_idx_r] <= out_data_l;
            otag[out_idx_r] <= done_cnt;
        end
        if (done_r) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer four beats; each beat held until in_ready is seen.
    task automatic send_vec(input logic [15:0] a, b, c, d);
        logic [15:0] v [4];
        int t;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = v[i];
            t = 0;
            while (!in_ready_r && t < 200) begin
                @(negedge clk);
                t++;
            end
            chk("in_ready_wait", 32'(t < 200), 32'd1);
            if (i == 0) begin
                first_cyc = cyc;
                cv_before = cv_r;
            end
            if (i == 3) last_cyc = cyc;
            @(negedge clk);
            if (i == 0) cv_after = cv_r;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int start);
        int t = 0;
        while (done_cnt == start && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("done_timeout", 32'(done_cnt != start), 32'd1);
    endtask

    task automatic check_out(input string tag, input int tagv,
                             input logic [15:0] r0, r1, r2, l0, l1, l2);
        chk({tag, "_r0"}, od_r[0], r0);
        chk({tag, "_r1"}, od_r[1], r1);
        chk({tag, "_r2"}, od_r[2], r2);
        chk({tag, "_l0"}, od_l[0], l0);
        chk({tag, "_l1"}, od_l[1], l1);
        chk({tag, "_l2"}, od_l[2], l2);
        for (int i = 0; i < 3; i++) chk({tag, "_seen"}, otag[i], tagv);
    endtask

    task automatic load_basic();
        for (int i = 0; i < 12; i++) wmem[i] = 16'h0000;
        wmem[0]  = 16'h0100;
        wmem[5]  = 16'h0100;
        wmem[7]  = 16'h0100;
        wmem[8]  = 16'hFF00;
        bmem[0]  = 16'h0000;
        bmem[1]  = 16'h0080;
        bmem[2]  = 16'h0000;
    endtask

    initial begin
        int d0;
        int t;
        logic [15:0] sd;
        logic [1:0]  si;
        logic [3:0]  sw;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        for (int i = 0; i < 12; i++) wmem[i] = '0;
        for (int i = 0; i < 3; i++) bmem[i] = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_in_ready", in_ready_r, 1'b1);
        chk("rst_out_valid", out_valid_r, 1'b0);
        chk("rst_done", done_r, 1'b0);
        chk("rst_class_valid", cv_r, 1'b0);
        chk("rst_w_addr", w_addr_r, 4'd0);
        chk("rst_out_data", out_data_r, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic MAC
        load_basic();
        d0 = done_cnt;
        send_vec(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        wait_done(d0);
        check_out("basic", d0, 16'h0100, 16'h0680, 16'h0000, 16'h0100, 16'h0680, 16'hFF00);
        chk("basic_latency", done_cyc - last_cyc, 22);
        chk("basic_cls_r", cls_r, 2'd1);
        chk("basic_cls_l", cls_l, 2'd1);
        chk("basic_cv", cv_r, 1'b1);

        // Saturation, positive
        for (int i = 0; i < 12; i++) wmem[i] = 16'h7FFF;
        for (int i = 0; i < 3; i++) bmem[i] = 16'h7FFF;
        d0 = done_cnt;
        send_vec(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        wait_done(d0);
        check_out("satp", d0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        chk("satp_cls", cls_l, 2'd0);

        // Saturation, negated weights
        for (int i = 0; i < 12; i++) wmem[i] = 16'h8001;
        d0 = done_cnt;
        send_vec(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        wait_done(d0);
        check_out("satn", d0, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h8000, 16'h8000);

        // Argmax with negatives and a tie
        for (int i = 0; i < 12; i++) wmem[i] = 16'h0000;
        for (int i = 0; i < 3; i++) bmem[i] = 16'h0000;
        wmem[0] = 16'hFD00; wmem[4] = 16'hFF00; wmem[8] = 16'hFF00;
        d0 = done_cnt;
        send_vec(16'h0100, 16'h0000, 16'h0000, 16'h0000);
        wait_done(d0);
        check_out("argmax", d0, 16'h0000, 16'h0000, 16'h0000, 16'hFD00, 16'hFF00, 16'hFF00);
        chk("argmax_cls_l", cls_l, 2'd1);
        chk("argmax_cls_r", cls_r, 2'd0);

        // Backpressure at neuron 1
        load_basic();
        d0 = done_cnt;
        send_vec(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        t = 0;
        while (!(out_valid_r && out_idx_r == 2'd0) && t < 100) begin @(negedge clk); t++; end
        chk("bp_wait0", 32'(t < 100), 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        t = 0;
        while (!out_valid_r && t < 100) begin @(negedge clk); t++; end
        chk("bp_wait1", 32'(t < 100), 32'd1);
        chk("bp_idx", out_idx_r, 2'd1);
        chk("bp_data", out_data_r, 16'h0680);
        sd = out_data_r; si = out_idx_r; sw = w_addr_r;
        for (int s = 1; s <= 5; s++) begin
            @(negedge clk);
            chk("bp_valid", out_valid_r, 1'b1);
            chk("bp_stable_data", out_data_r, sd);
            chk("bp_stable_idx", out_idx_l, si);
            chk("bp_stable_waddr", w_addr_r, sw);
            chk("bp_stable_baddr", b_addr_r, 2'd1);
        end
        out_ready = 1'b1;
        wait_done(d0);
        chk("bp_latency", done_cyc - last_cyc, 27);
        check_out("bp", d0, 16'h0100, 16'h0680, 16'h0000, 16'h0100, 16'h0680, 16'hFF00);

        // Reset mid-MAC: neuron 1, k=2
        d0 = done_cnt;
        send_vec(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        repeat (10) @(negedge clk);
        chk("midmac_waddr", w_addr_r, 4'd7);
        chk("midmac_baddr", b_addr_r, 2'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_w_addr", w_addr_r, 4'd0);
        chk("arst_b_addr", b_addr_r, 2'd0);
        chk("arst_in_ready", in_ready_l, 1'b1);
        chk("arst_out_valid", out_valid_l, 1'b0);
        chk("arst_done", done_l, 1'b0);
        chk("arst_class_valid", cv_r, 1'b0);
        chk("arst_class_idx", cls_r, 2'd0);
        chk("arst_out_idx", out_idx_r, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_in_ready_rel", in_ready_r, 1'b1);
        d0 = done_cnt;
        send_vec(16'h0200, 16'h0100, 16'h0000, 16'h0000);
        chk("arst_cv_busy", cv_l, 1'b0);
        repeat (10) @(negedge clk);
        chk("arst_cv_busy2", cv_r, 1'b0);
        wait_done(d0);
        check_out("fresh", d0, 16'h0200, 16'h0180, 16'h0000, 16'h0200, 16'h0180, 16'hFE00);
        chk("fresh_cls", cls_r, 2'd0);
        chk("fresh_cv", cv_l, 1'b1);

        // Back-to-back vectors: B offered continuously from the end of A
        d0 = done_cnt;
        send_vec(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        send_vec(16'h0200, 16'h0100, 16'h0000, 16'h0000);
        chk("b2b_a_done", done_cnt, d0 + 1);
        chk("b2b_first_beat", first_cyc, done_cyc + 1);
        chk("b2b_cv_before", cv_before, 1'b1);
        chk("b2b_cv_after", cv_after, 1'b0);
        check_out("b2b_a", d0, 16'h0100, 16'h0680, 16'h0000, 16'h0100, 16'h0680, 16'hFF00);
        wait_done(d0 + 1);
        check_out("b2b_b", d0 + 1, 16'h0200, 16'h0180, 16'h0000, 16'h0200, 16'h0180, 16'hFE00);
        chk("b2b_b_cls", cls_l, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fc_layer_seq.md
# fc_layer_seq

Parametrised, sequential fully-connected layer engine with built-in argmax, the successor to the fixed 120→84→10 dense stage of the classifier. It accepts one input vector over a ready/valid stream and computes every output neuron with a single signed fixed-point MAC, reading weights and biases from external synchronous memories. It then streams the activations out and reports the index of the largest output. Instances chain to form the dense stack; the last instance's class index is the network result.

## Interface
- IN_N, 120: input vector length (≥2)
- OUT_N, 84: output neuron count (≥1)
- DW, 16: data/weight/bias width, signed two's complement
- FRAC, 8: fractional bits of the Q format, common to data, weight and bias
- RELU, 1: 1 clamps negative results to 0; 0 passes them through
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid / in_ready  in / out  1  input vector beat handshake
- in_data  in  DW  input element, element 0 first
- w_addr  out  clog2(IN_N*OUT_N)  weight address, row-major: neuron j, element k at j*IN_N+k
- w_rdata  in  DW  weight, valid one cycle after w_addr
- b_addr  out  clog2(OUT_N)  bias address
- b_rdata  in  DW  bias, valid one cycle after b_addr
- out_valid / out_ready  out / in  1  activation handshake
- out_data  out  DW  activation
- out_idx  out  clog2(OUT_N)  neuron index of out_data
- done  out  1  one-cycle pulse after last activation accepted
- class_idx  out  clog2(OUT_N)  argmax index, held until next input beat accepted
- class_valid  out  1  class_idx is valid

## Operation
- States: LOAD, BIAS, MAC, POST, OUT, DONE.
- LOAD: in_ready=1. Each accepted beat writes x[k] and increments k. On the IN_N-th beat go to BIAS, j=0. Accepting the first beat clears class_valid.
- BIAS: drive b_addr=j and w_addr=j*IN_N. Go to MAC, k=0.
- MAC: one cycle per element. At k=0, acc = sext(bias)<<FRAC + x[0]*w_rdata. Otherwise acc += x[k]*w_rdata. Issue w_addr for k+1 in the same cycle. After k=IN_N-1 go to POST.
- Widths: product 2*DW signed. Accumulator ACC_W = 2*DW + clog2(IN_N) + 1, with no internal overflow.
- POST: r = acc >>> FRAC (arithmetic shift, truncation toward −inf).
  - Saturate r to [−2^(DW−1), 2^(DW−1)−1].
  - If RELU=1 and r<0, r=0.
  - Register r to out_data and j to out_idx.
  - Argmax update: j=0 loads best=r, bi=0. For j>0, update only if r > best (signed, strict), so the lowest index wins ties. Negative values compete normally.
  - Go to OUT.
- OUT: out_valid=1. out_data and out_idx are held stable until out_ready. On handshake: if j<OUT_N−1, j++ and go to BIAS; otherwise go to DONE.
- DONE: done=1 for one cycle. class_idx=bi, class_valid=1. Go to LOAD.
- in_ready=0 in every state except LOAD. Input beats offered outside LOAD are not consumed.
- Reset (asynchronous, any state, including mid-MAC or mid-OUT):
  - State goes to LOAD, k=j=0, acc cleared.
  - Outputs: in_ready=1 (LOAD), out_valid=0, out_data=0, out_idx=0, done=0, class_idx=0, class_valid=0, w_addr=0, b_addr=0.
  - x buffer contents are don't-care.

## Timing
- Load: IN_N cycles minimum, one element per cycle at full throughput.
- Per neuron: BIAS 1 + MAC IN_N + POST 1 + OUT ≥1 cycles. With out_ready held high this is IN_N+3 cycles.
- First out_valid: IN_N+2 cycles after the LOAD→BIAS transition.
- done: asserted the cycle after the last OUT handshake. class_valid rises in the same cycle.
- Total latency, last input beat to done, with out_ready=1: OUT_N*(IN_N+3)+1 cycles.
- Back-to-back: LOAD is entered the cycle after DONE. A new vector may start immediately.

## Test plan
Bench parameters: IN_N=4, OUT_N=3, DW=16, FRAC=8, unless stated.

- **Basic MAC:** x=[0x0100,0x0200,0x0300,0x0400], W rows=[1,0,0,0],[0,1,0,1],[−1,0,0,0] (×0x0100), bias=[0,0x0080,0]. Required with RELU=1: out 0x0100, 0x0680, 0x0000; class_idx=1; done one cycle after the 3rd handshake, 22 cycles after the last input beat.
- **Saturation:** all x and w =0x7FFF, bias 0x7FFF. Required: out_data=0x7FFF. Negate w with RELU=0: out_data=0x8000.
- **Argmax, RELU=0:** results −3, −1, −1 (0xFD00, 0xFF00, 0xFF00). Required: class_idx=1 (lowest index wins ties; negatives counted).
- **Backpressure:** hold out_ready=0 for 5 cycles at neuron 1. Required: out_valid stays 1, out_data and out_idx stable; no w_addr/b_addr activity; done is delayed by exactly 5 cycles.
- **Reset mid-MAC:** assert rst_n=0 at neuron 1, k=2. Required: all outputs at reset values immediately; in_ready=1 after release. A fresh vector then produces correct results; class_valid stays 0 until its done.
- **Back-to-back vectors:** offer vector B continuously from done. Required: first B beat accepted the cycle after done; class_valid drops on that beat; B results are correct.
